// File: rtl/apb_serial_alu_pkg.sv
// Shared types and constants for the APB serial ALU: operation codes,
// register offsets, STATUS/CTRL bit positions and engine states.
package apb_serial_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_RUN  = 2'd1,
        ENG_DONE = 2'd2
    } eng_state_e;

    localparam logic [7:0] OFF_OPA    = 8'h00;
    localparam logic [7:0] OFF_OPB    = 8'h04;
    localparam logic [7:0] OFF_CTRL   = 8'h08;
    localparam logic [7:0] OFF_RESULT = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;

    localparam int ST_BUSY  = 0;
    localparam int ST_DONE  = 1;
    localparam int ST_CARRY = 2;
    localparam int ST_OVF   = 3;

    localparam int CTRL_START_BIT = 31;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

endpackage

// File: rtl/apb_serial_alu_if.sv
// APB completer-side bus bundle for the serial ALU; clock and reset stay
// outside the interface.
interface apb_serial_alu_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_serial_alu_engine.sv
// Chunk-serial arithmetic/logic engine: processes CHUNK bits per cycle, LSB
// chunk first, with a registered carry between chunks.
module alu_serial_engine
    import apb_serial_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CHUNK  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  alu_op_e           op_i,
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    output logic              busy_o,
    output logic              done_pulse_o,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              ovf_o
);
    localparam int N     = DATA_W / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    eng_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              c_q, c_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;

    logic              sub_s, arith_s, last_s;
    logic [CHUNK-1:0]  opa_c_s, opb_c_s, opb_eff_s, chunk_res_s;
    logic [CHUNK:0]    sum_s;

    assign sub_s     = (op_i == OP_SUB);
    assign arith_s   = (op_i == OP_ADD) || (op_i == OP_SUB);
    assign last_s    = (cnt_q == CNT_W'(N - 1));
    assign opa_c_s   = opa_i[int'(cnt_q) * CHUNK +: CHUNK];
    assign opb_c_s   = opb_i[int'(cnt_q) * CHUNK +: CHUNK];
    assign opb_eff_s = sub_s ? ~opb_c_s : opb_c_s;
    assign sum_s     = {1'b0, opa_c_s} + {1'b0, opb_eff_s} + (CHUNK + 1)'(c_q);

    always_comb begin
        chunk_res_s = '0;
        case (op_i)
            OP_ADD, OP_SUB: chunk_res_s = sum_s[CHUNK-1:0];
            OP_AND:         chunk_res_s = opa_c_s & opb_c_s;
            OP_OR:          chunk_res_s = opa_c_s | opb_c_s;
            OP_XOR:         chunk_res_s = opa_c_s ^ opb_c_s;
            default:        chunk_res_s = '0;
        endcase
    end

    // Next-state: IDLE waits for start, RUN walks the chunks, DONE lasts one cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        case (state_q)
            ENG_IDLE: begin
                if (start_i) begin
                    state_d = ENG_RUN;
                    cnt_d   = '0;
                    c_d     = sub_s;
                end else begin
                    state_d = ENG_IDLE;
                end
            end
            ENG_RUN: begin
                result_d[int'(cnt_q) * CHUNK +: CHUNK] = chunk_res_s;
                c_d = sum_s[CHUNK];
                if (last_s) begin
                    state_d = ENG_DONE;
                    carry_d = arith_s & sum_s[CHUNK];
                    ovf_d   = arith_s & (opa_i[DATA_W-1] == opb_eff_s[CHUNK-1])
                                      & (chunk_res_s[CHUNK-1] != opa_i[DATA_W-1]);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ENG_DONE: state_d = ENG_IDLE;
            default:  state_d = ENG_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ENG_IDLE;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    // The pending start cycle already counts as busy so no write can slip in.
    assign busy_o       = start_i | (state_q == ENG_RUN);
    assign done_pulse_o = (state_q == ENG_DONE);
    assign result_o     = result_q;
    assign carry_o      = carry_q;
    assign ovf_o        = ovf_q;

endmodule

// File: rtl/apb_serial_alu.sv
// APB completer front end for the serial ALU: address decode, register file,
// error responses and the RESULT-read stall while a computation is running.
module apb_serial_alu
    import apb_serial_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int CHUNK  = 4
) (
    input  logic            PCLK,
    input  logic            PRESET,
    apb_serial_alu_if.slave apb,
    output logic            done_irq
);
    localparam int START_BIT = (DATA_W > CTRL_START_BIT) ? CTRL_START_BIT : DATA_W - 1;

    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
    alu_op_e           op_q, op_d;
    logic              start_q, start_d;
    logic              done_q, done_d;

    logic              eng_busy_s, eng_done_s, eng_carry_s, eng_ovf_s;
    logic [DATA_W-1:0] eng_result_s;

    logic hit_opa_s, hit_opb_s, hit_ctrl_s, hit_result_s, hit_status_s;
    logic aligned_s, mapped_s, err_s, stall_s, ready_s, commit_s;
    logic wr_commit_s, status_rd_s;
    logic [DATA_W-1:0] rd_data_s, status_s, ctrl_s;

    assign hit_opa_s    = (apb.PADDR == ADDR_W'(OFF_OPA));
    assign hit_opb_s    = (apb.PADDR == ADDR_W'(OFF_OPB));
    assign hit_ctrl_s   = (apb.PADDR == ADDR_W'(OFF_CTRL));
    assign hit_result_s = (apb.PADDR == ADDR_W'(OFF_RESULT));
    assign hit_status_s = (apb.PADDR == ADDR_W'(OFF_STATUS));
    assign aligned_s    = (apb.PADDR[1:0] == 2'b00);
    assign mapped_s     = hit_opa_s | hit_opb_s | hit_ctrl_s | hit_result_s | hit_status_s;

    always_comb begin
        err_s = 1'b0;
        if (!aligned_s || !mapped_s) begin
            err_s = 1'b1;
        end else if (apb.PWRITE) begin
            if (hit_result_s || hit_status_s) begin
                err_s = 1'b1;
            end else if (eng_busy_s) begin
                err_s = 1'b1;
            end else if (hit_ctrl_s && !op_is_legal(apb.PWDATA[2:0])) begin
                err_s = 1'b1;
            end else begin
                err_s = 1'b0;
            end
        end else begin
            err_s = 1'b0;
        end
    end

    // PREADY is gated by reset so an abandoned stalled transfer drops at once.
    assign stall_s     = !apb.PWRITE && hit_result_s && eng_busy_s;
    assign ready_s     = apb.PSEL && apb.PENABLE && !stall_s && !PRESET;
    assign commit_s    = ready_s && !err_s;
    assign wr_commit_s = commit_s && apb.PWRITE;
    assign status_rd_s = commit_s && !apb.PWRITE && hit_status_s;

    always_comb begin
        status_s           = '0;
        status_s[ST_BUSY]  = eng_busy_s;
        status_s[ST_DONE]  = done_q | eng_done_s;
        status_s[ST_CARRY] = eng_carry_s;
        status_s[ST_OVF]   = eng_ovf_s;
        ctrl_s             = '0;
        ctrl_s[2:0]        = op_q;
        rd_data_s          = '0;
        if (hit_opa_s) begin
            rd_data_s = opa_q;
        end else if (hit_opb_s) begin
            rd_data_s = opb_q;
        end else if (hit_ctrl_s) begin
            rd_data_s = ctrl_s;
        end else if (hit_result_s) begin
            rd_data_s = eng_result_s;
        end else if (hit_status_s) begin
            rd_data_s = status_s;
        end else begin
            rd_data_s = '0;
        end
    end

    assign apb.PREADY  = ready_s;
    assign apb.PSLVERR = ready_s && err_s;
    assign apb.PRDATA  = (commit_s && !apb.PWRITE) ? rd_data_s : '0;

    // Register writes; a new START wins over a completion landing on the same edge.
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        op_d    = op_q;
        start_d = 1'b0;
        if (wr_commit_s) begin
            if (hit_opa_s) begin
                opa_d = apb.PWDATA;
            end else if (hit_opb_s) begin
                opb_d = apb.PWDATA;
            end else if (hit_ctrl_s) begin
                op_d    = alu_op_e'(apb.PWDATA[2:0]);
                start_d = apb.PWDATA[START_BIT];
            end else begin
                start_d = 1'b0;
            end
        end else begin
            start_d = 1'b0;
        end
        if (start_d) begin
            done_d = 1'b0;
        end else if (eng_done_s) begin
            done_d = 1'b1;
        end else if (status_rd_s) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= OP_ADD;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    alu_serial_engine #(
        .DATA_W (DATA_W),
        .CHUNK  (CHUNK)
    ) u_engine (
        .clk_i        (PCLK),
        .rst_i        (PRESET),
        .start_i      (start_q),
        .op_i         (op_q),
        .opa_i        (opa_q),
        .opb_i        (opb_q),
        .busy_o       (eng_busy_s),
        .done_pulse_o (eng_done_s),
        .result_o     (eng_result_s),
        .carry_o      (eng_carry_s),
        .ovf_o        (eng_ovf_s)
    );

    assign done_irq = eng_done_s;

endmodule

// File: tb/tb_apb_serial_alu.sv
// Directed bench for apb_serial_alu: table of operations with hand-computed
// results and status, plus sequences for stall, errors and mid-run reset.
module tb_apb_serial_alu;
    logic PCLK;
    logic PRESET;
    logic done_irq;
    int   total;
    int   bad;

    apb_serial_alu_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    apb_serial_alu #(.DATA_W(32), .ADDR_W(8), .CHUNK(4)) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .apb      (bus),
        .done_irq (done_irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] opa;
        logic [31:0] opb;
        logic [31:0] ctrl;
        logic [31:0] exp_res;
        logic [31:0] exp_st;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One APB transfer; called and returning just after a rising edge.
    task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int waits);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wd;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        waits = 0;
        @(negedge PCLK);
        while (!bus.PREADY && waits < 50) begin
            waits++;
            @(negedge PCLK);
        end
        if (!bus.PREADY) check("pready_timeout", {31'd0, bus.PREADY}, 32'd1);
        rd  = bus.PRDATA;
        err = bus.PSLVERR;
        @(posedge PCLK); #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp,
                          input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          w;
        apb(1'b0, a, 32'd0, rd, er, w);
        check({nm, "_data"}, rd, exp);
        check({nm, "_err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    task automatic wr_chk(input string nm, input logic [7:0] a, input logic [31:0] d,
                          input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          w;
        apb(1'b1, a, d, rd, er, w);
        check({nm, "_err"}, {31'd0, er}, {31'd0, exp_err});
        check({nm, "_waits"}, 32'(w), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w;
        int          first;
        int          pulses;
        total = 0;
        bad   = 0;

        vecs[0] = '{32'd5,        32'd7,        32'h8000_0000, 32'h0000_000C, 32'h2};
        vecs[1] = '{32'hFFFF_FFFF, 32'd1,       32'h8000_0000, 32'h0000_0000, 32'h6};
        vecs[2] = '{32'h7FFF_FFFF, 32'd1,       32'h8000_0000, 32'h8000_0000, 32'hA};
        vecs[3] = '{32'd3,        32'd5,        32'h8000_0001, 32'hFFFF_FFFE, 32'h2};
        vecs[4] = '{32'd5,        32'd3,        32'h8000_0001, 32'h0000_0002, 32'h6};
        vecs[5] = '{32'h8000_0000, 32'd1,       32'h8000_0001, 32'h7FFF_FFFF, 32'hE};
        vecs[6] = '{32'h0000_00F0, 32'h0000_003C, 32'h8000_0004, 32'h0000_00CC, 32'h2};
        vecs[7] = '{32'h0000_F0F0, 32'h0000_FF00, 32'h8000_0002, 32'h0000_F000, 32'h2};
        vecs[8] = '{32'h0000_00F0, 32'h0000_000F, 32'h8000_0003, 32'h0000_00FF, 32'h2};

        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = 8'h00; bus.PWDATA = 32'd0;
        PRESET = 1'b1;
        #2;
        check("rst_pready",  {31'd0, bus.PREADY},  32'd0);
        check("rst_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
        check("rst_prdata",  bus.PRDATA,           32'd0);
        check("rst_irq",     {31'd0, done_irq},    32'd0);
        @(posedge PCLK); @(posedge PCLK); #1;
        PRESET = 1'b0;

        rd_chk("rst_opa",    8'h00, 32'd0, 1'b0);
        rd_chk("rst_opb",    8'h04, 32'd0, 1'b0);
        rd_chk("rst_ctrl",   8'h08, 32'd0, 1'b0);
        rd_chk("rst_result", 8'h0C, 32'd0, 1'b0);
        rd_chk("rst_status", 8'h10, 32'd0, 1'b0);

        // Basic add: latency to done_irq and single pulse
        wr_chk("add_opa",  8'h00, 32'd5, 1'b0);
        wr_chk("add_opb",  8'h04, 32'd7, 1'b0);
        wr_chk("add_ctrl", 8'h08, 32'h8000_0000, 1'b0);
        first = 0; pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge PCLK); #1;
            if (done_irq) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        check("add_latency", 32'(first), 32'd9);
        check("add_pulses",  32'(pulses), 32'd1);
        rd_chk("add_status",  8'h10, 32'h2, 1'b0);
        rd_chk("add_status2", 8'h10, 32'h0, 1'b0);
        rd_chk("add_result",  8'h0C, 32'd12, 1'b0);
        rd_chk("add_ctrl_rd", 8'h08, 32'd0, 1'b0);

        // Table: start, then read RESULT at once (stalls 8 access cycles)
        for (int i = 0; i < 9; i++) begin
            wr_chk($sformatf("v%0d_opa", i), 8'h00, vecs[i].opa, 1'b0);
            wr_chk($sformatf("v%0d_opb", i), 8'h04, vecs[i].opb, 1'b0);
            wr_chk($sformatf("v%0d_ctrl", i), 8'h08, vecs[i].ctrl, 1'b0);
            apb(1'b0, 8'h0C, 32'd0, rd, er, w);
            check($sformatf("v%0d_result", i), rd, vecs[i].exp_res);
            check($sformatf("v%0d_stall", i), 32'(w), 32'd8);
            check($sformatf("v%0d_res_err", i), {31'd0, er}, 32'd0);
            rd_chk($sformatf("v%0d_status", i), 8'h10, vecs[i].exp_st, 1'b0);
        end
        rd_chk("sub_ctrl_rd", 8'h08, 32'd3, 1'b0);

        // Errors while busy and on bad accesses
        wr_chk("e_opa",  8'h00, 32'd5, 1'b0);
        wr_chk("e_opb",  8'h04, 32'd7, 1'b0);
        wr_chk("e_ctrl", 8'h08, 32'h8000_0000, 1'b0);
        rd_chk("e_busy_status", 8'h10, 32'h1, 1'b0);
        wr_chk("e_opa_busy", 8'h00, 32'd9, 1'b1);
        rd_chk("e_opa_kept", 8'h00, 32'd5, 1'b0);
        wr_chk("e_ctrl_busy", 8'h08, 32'h8000_0001, 1'b1);
        rd_chk("e_result", 8'h0C, 32'd12, 1'b0);
        rd_chk("e_ctrl_kept", 8'h08, 32'd0, 1'b0);
        rd_chk("e_unmapped", 8'h14, 32'd0, 1'b1);
        rd_chk("e_misalign", 8'h02, 32'd0, 1'b1);
        wr_chk("e_wr_result", 8'h0C, 32'd1, 1'b1);
        wr_chk("e_wr_status", 8'h10, 32'd1, 1'b1);
        wr_chk("e_bad_op", 8'h08, 32'h8000_0006, 1'b1);
        rd_chk("e_badop_kept", 8'h08, 32'd0, 1'b0);
        wr_chk("e_op_only", 8'h08, 32'd3, 1'b0);
        rd_chk("e_op_only_rd", 8'h08, 32'd3, 1'b0);
        rd_chk("e_done_kept", 8'h10, 32'h2, 1'b0);
        rd_chk("e_done_clr", 8'h10, 32'h0, 1'b0);

        // Reset during a stalled RESULT read
        wr_chk("r_opa",  8'h00, 32'd5, 1'b0);
        wr_chk("r_opb",  8'h04, 32'd7, 1'b0);
        wr_chk("r_ctrl", 8'h08, 32'h8000_0000, 1'b0);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 8'h0C;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        repeat (3) @(posedge PCLK);
        #3;
        check("r_stalled", {31'd0, bus.PREADY}, 32'd0);
        PRESET = 1'b1;
        #1;
        check("r_pready_async", {31'd0, bus.PREADY}, 32'd0);
        check("r_prdata_async", bus.PRDATA, 32'd0);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        rd_chk("r_status", 8'h10, 32'h0, 1'b0);
        rd_chk("r_result", 8'h0C, 32'd0, 1'b0);
        rd_chk("r_opa_rd", 8'h00, 32'd0, 1'b0);
        wr_chk("r2_opa",  8'h00, 32'd5, 1'b0);
        wr_chk("r2_opb",  8'h04, 32'd7, 1'b0);
        wr_chk("r2_ctrl", 8'h08, 32'h8000_0000, 1'b0);
        apb(1'b0, 8'h0C, 32'd0, rd, er, w);
        check("r2_result", rd, 32'd12);
        check("r2_stall", 32'(w), 32'd8);
        check("r2_err", {31'd0, er}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
